// File: rtl/sreg_shifter.sv
// sreg_shifter: serial shift-register engine between the command FSM and the pixel IC
// config/readout chain. One command (op, bit length, data) is accepted per handshake; the engine
// then drives shift/sclk/serial_out with a programmable sclk half-period, deserialises N_CH
// readout lanes into data_out and, for WRITE_CFG, issues a timed write_cfg strobe.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_op            00 WRITE, 01 WRITE_CFG, 10 READ, 11 FLUSH
//   cmd_len           number of bits to shift (0 skips the bit phases)
//   data_in           write data, MSB shifted first
//   data_out          captured readout data; lane k fills data_out[DATA_W-1-k*LANE_W -: LANE_W]
//   dout_valid        1-cycle pulse when data_out has been updated by a capture
//   busy              high from accept until back in idle
//   sreg_in           serial readout lanes from the IC
//   shift, sclk       IC shift enable and shift clock (sclk idles high)
//   serial_out        IC serial data in
//   write_cfg         IC config latch strobe
//
// Build option: define SREG_READBACK_EN to make WRITE/WRITE_CFG capture the lanes as READ does
// (full duplex) and pulse dout_valid at the end of the write.
module sreg_shifter #(
  parameter int unsigned DATA_W   = 42,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned CNT_W    = 7,
  parameter int unsigned SCLK_DIV = 1,
  parameter int unsigned CFG_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              dout_valid,
  output logic              busy,
  input  logic [N_CH-1:0]   sreg_in,
  output logic              shift,
  output logic              sclk,
  output logic              serial_out,
  output logic              write_cfg
);

  localparam int unsigned LANE_W = DATA_W / N_CH;
  localparam int unsigned DivW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned CfgCW  = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(SCLK_DIV - 1);
  localparam logic [CfgCW-1:0] CfgLast = CfgCW'(CFG_W - 1);

  typedef enum logic [1:0] {
    OpWrite    = 2'b00,
    OpWriteCfg = 2'b01,
    OpRead     = 2'b10,
    OpFlush    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StCfg,
    StDone
  } state_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              len_nz_q, len_nz_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [CfgCW-1:0]  cfg_cnt_q, cfg_cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              dout_valid_q, dout_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              shift_q, shift_d;
  logic              sclk_q, sclk_d;
  logic              serial_out_q, serial_out_d;
  logic              write_cfg_q, write_cfg_d;

  logic              is_write;
  logic              capture_op;
  logic              go_low;
  logic [DATA_W-1:0] lanes_shifted;

  assign is_write = (op_q == OpWrite) || (op_q == OpWriteCfg);

`ifdef SREG_READBACK_EN
  assign capture_op = (op_q != OpFlush);
`else
  assign capture_op = (op_q == OpRead);
`endif

  // Every lane slice moves up one bit and takes its lane's new bit at the slice LSB.
  always_comb begin
    lanes_shifted = data_out_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      lanes_shifted[DATA_W-1-k*LANE_W -: LANE_W] =
          (data_out_q[DATA_W-1-k*LANE_W -: LANE_W] << 1) | LANE_W'(sreg_in[k]);
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    bit_cnt_d    = bit_cnt_q;
    len_nz_d     = len_nz_q;
    div_cnt_d    = div_cnt_q;
    cfg_cnt_d    = cfg_cnt_q;
    tx_d         = tx_q;
    data_out_d   = data_out_q;
    dout_valid_d = 1'b0;
    cmd_ready_d  = cmd_ready_q;
    busy_d       = busy_q;
    shift_d      = shift_q;
    sclk_d       = sclk_q;
    serial_out_d = serial_out_q;
    write_cfg_d  = write_cfg_q;
    go_low       = 1'b0;

    case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          op_d        = op_e'(cmd_op);
          tx_d        = data_in;
          bit_cnt_d   = cmd_len;
          len_nz_d    = |cmd_len;
          if (cmd_len != '0) begin
            state_d      = StSetup;
            shift_d      = 1'b1;
            sclk_d       = 1'b1;
            serial_out_d = 1'b0;
            div_cnt_d    = DivLast;
          end else if (op_e'(cmd_op) == OpWriteCfg) begin
            state_d     = StCfg;
            write_cfg_d = 1'b1;
            cfg_cnt_d   = CfgLast;
          end else begin
            state_d = StDone;
          end
        end
      end

      StSetup: begin
        if (div_cnt_q == '0) begin
          go_low = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      StLow: begin
        if (div_cnt_q == '0) begin
          // This edge raises sclk, which is where the IC lanes are sampled.
          state_d   = StHigh;
          sclk_d    = 1'b1;
          div_cnt_d = DivLast;
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (capture_op) begin
            data_out_d = lanes_shifted;
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      StHigh: begin
        if (div_cnt_q == '0) begin
          if (bit_cnt_q != '0) begin
            go_low = 1'b1;
          end else begin
            shift_d      = 1'b0;
            serial_out_d = 1'b0;
            if (op_q == OpWriteCfg) begin
              state_d     = StCfg;
              write_cfg_d = 1'b1;
              cfg_cnt_d   = CfgLast;
            end else begin
              state_d      = StDone;
              dout_valid_d = capture_op;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      StCfg: begin
        if (cfg_cnt_q == '0) begin
          state_d      = StDone;
          write_cfg_d  = 1'b0;
          // A zero-length WRITE_CFG captured nothing, so it must not announce new data.
          dout_valid_d = capture_op && len_nz_q;
        end else begin
          cfg_cnt_d = cfg_cnt_q - 1'b1;
        end
      end

      StDone: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared entry into a bit's low phase from SETUP or from the previous bit's high phase.
    if (go_low) begin
      state_d      = StLow;
      sclk_d       = 1'b0;
      div_cnt_d    = DivLast;
      serial_out_d = is_write & tx_q[DATA_W-1];
      tx_d         = tx_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= OpWrite;
      bit_cnt_q    <= '0;
      len_nz_q     <= 1'b0;
      div_cnt_q    <= '0;
      cfg_cnt_q    <= '0;
      tx_q         <= '0;
      data_out_q   <= '0;
      dout_valid_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      shift_q      <= 1'b0;
      sclk_q       <= 1'b1;
      serial_out_q <= 1'b0;
      write_cfg_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      bit_cnt_q    <= bit_cnt_d;
      len_nz_q     <= len_nz_d;
      div_cnt_q    <= div_cnt_d;
      cfg_cnt_q    <= cfg_cnt_d;
      tx_q         <= tx_d;
      data_out_q   <= data_out_d;
      dout_valid_q <= dout_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      shift_q      <= shift_d;
      sclk_q       <= sclk_d;
      serial_out_q <= serial_out_d;
      write_cfg_q  <= write_cfg_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign dout_valid = dout_valid_q;
  assign shift      = shift_q;
  assign sclk       = sclk_q;
  assign serial_out = serial_out_q;
  assign write_cfg  = write_cfg_q;

endmodule

// File: tb/tb_sreg_shifter.sv
// Self-checking bench for sreg_shifter: directed and randomized commands checked against a
// queue-based model of the shift protocol, plus reset behaviour.
module tb_sreg_shifter;

  localparam int unsigned DATA_W   = 42;
  localparam int unsigned N_CH     = 2;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned SCLK_DIV = 1;
  localparam int unsigned CFG_W    = 2;
  localparam int unsigned LANE_W   = DATA_W / N_CH;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_len;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              dout_valid;
  logic              busy;
  logic [N_CH-1:0]   sreg_in;
  logic              shift;
  logic              sclk;
  logic              serial_out;
  logic              write_cfg;

  sreg_shifter #(
    .DATA_W  (DATA_W),
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .SCLK_DIV(SCLK_DIV),
    .CFG_W   (CFG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .data_in   (data_in),
    .data_out  (data_out),
    .dout_valid(dout_valid),
    .busy      (busy),
    .sreg_in   (sreg_in),
    .shift     (shift),
    .sclk      (sclk),
    .serial_out(serial_out),
    .write_cfg (write_cfg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model_dout;
  bit                lane_bits [N_CH][128];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_lanes_random();
    for (int k = 0; k < N_CH; k++)
      for (int b = 0; b < 128; b++) lane_bits[k][b] = bit'($urandom_range(0, 1));
  endtask

  // Slice after a capture = the last LANE_W bits of (old slice bits, then the received stream).
  function automatic logic [LANE_W-1:0] model_lane(input logic [LANE_W-1:0] old, input int k,
                                                   input int len);
    bit q[$];
    logic [LANE_W-1:0] r;
    for (int i = LANE_W - 1; i >= 0; i--) q.push_back(old[i]);
    for (int b = 0; b < len; b++) q.push_back(lane_bits[k][b]);
    r = '0;
    for (int i = 0; i < LANE_W; i++) r[i] = q[q.size() - 1 - i];
    return r;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input int len, input logic [DATA_W-1:0] d);
    int           guard, busy_cnt, rises, cfg_cycles, cfg_shift_bad, low_noshift, dv, exp_busy;
    logic         prev_sclk;
    logic [127:0] obs_ser, exp_ser;
    bit           cap;
    string        pfx;
    pfx = $sformatf("op%0d_len%0d", op, len);

    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({pfx, "_ready_before"}, cmd_ready, 1);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = CNT_W'(len);
    data_in   = d;
    sreg_in   = '0;
    @(negedge clk);
    cmd_valid = 1'b0;

    busy_cnt = 0; rises = 0; cfg_cycles = 0; cfg_shift_bad = 0; low_noshift = 0; dv = 0;
    prev_sclk = 1'b1;
    obs_ser = '0;
    while (busy === 1'b1 && busy_cnt < 2000) begin
      busy_cnt++;
      if (prev_sclk === 1'b0 && sclk === 1'b1) begin
        if (rises < 128) obs_ser[rises] = serial_out;
        rises++;
      end
      if (write_cfg === 1'b1) begin
        cfg_cycles++;
        if (shift !== 1'b0) cfg_shift_bad++;
      end
      if (sclk === 1'b0 && shift !== 1'b1) low_noshift++;
      if (dout_valid === 1'b1) dv++;
      for (int k = 0; k < N_CH; k++) sreg_in[k] = (rises < 128) ? lane_bits[k][rises] : 1'b0;
      prev_sclk = sclk;
      @(negedge clk);
    end

    // Expected behaviour from the protocol rules.
    if (len == 0) exp_busy = ((op == 2'b01) ? CFG_W : 0) + 1;
    else exp_busy = SCLK_DIV * (1 + 2 * len) + ((op == 2'b01) ? CFG_W : 0) + 1;
    exp_ser = '0;
    for (int i = 0; i < len; i++)
      if ((op == 2'b00 || op == 2'b01) && i < DATA_W) exp_ser[i] = d[DATA_W-1-i];
`ifdef SREG_READBACK_EN
    cap = (op != 2'b11);
`else
    cap = (op == 2'b10);
`endif
    if (cap && len > 0)
      for (int k = 0; k < N_CH; k++)
        model_dout[DATA_W-1-k*LANE_W -: LANE_W] =
            model_lane(model_dout[DATA_W-1-k*LANE_W -: LANE_W], k, len);

    check({pfx, "_busy_cycles"}, busy_cnt, exp_busy);
    check({pfx, "_sclk_rises"}, rises, len);
    check({pfx, "_serial_bits"}, obs_ser, exp_ser);
    check({pfx, "_cfg_cycles"}, cfg_cycles, (op == 2'b01) ? CFG_W : 0);
    check({pfx, "_cfg_shift"}, cfg_shift_bad, 0);
    check({pfx, "_low_shift"}, low_noshift, 0);
    check({pfx, "_dout_valid"}, dv, (cap && len > 0) ? 1 : 0);
    check({pfx, "_data_out"}, data_out, model_dout);
    check({pfx, "_ready_after"}, cmd_ready, 1);
    check({pfx, "_sclk_idle"}, sclk, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [1:0]        op;
    int                len;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; data_in = '0; sreg_in = '0;
    model_dout = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_shift", shift, 0);
    check("rst_sclk", sclk, 1);
    check("rst_serial_out", serial_out, 0);
    check("rst_write_cfg", write_cfg, 0);
    check("rst_data_out", data_out, 0);
    check("rst_dout_valid", dout_valid, 0);
    rst = 1'b0;
    #1 check("ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);

    // Directed cases.
    fill_lanes_random();
    run_cmd(2'b00, 42, 42'h300_0000_0001);
    fill_lanes_random();
    run_cmd(2'b01, 20, DATA_W'({$urandom(), $urandom()}));
    for (int b = 0; b < 128; b++) begin
      lane_bits[0][b] = (b % 2 == 0);
      lane_bits[1][b] = 1'b1;
    end
    run_cmd(2'b10, 21, '0);
    check("read21_pattern", data_out, {21'h155555, 21'h1FFFFF});
    fill_lanes_random();
    run_cmd(2'b10, 25, '0);
    fill_lanes_random();
    run_cmd(2'b11, 6, DATA_W'({$urandom(), $urandom()}));
    for (int o = 0; o < 4; o++) begin
      fill_lanes_random();
      run_cmd(2'(o), 0, DATA_W'({$urandom(), $urandom()}));
    end
    fill_lanes_random();
    run_cmd(2'b10, 5, '0);
    fill_lanes_random();
    run_cmd(2'b10, 127, '0);

    // Randomized commands.
    for (int n = 0; n < 24; n++) begin
      fill_lanes_random();
      op  = 2'($urandom_range(0, 3));
      len = (n % 6 == 5) ? int'($urandom_range(43, 127)) : int'($urandom_range(0, 45));
      d   = DATA_W'({$urandom(), $urandom()});
      run_cmd(op, len, d);
    end

    // Reset in the middle of a WRITE.
    fill_lanes_random();
    check("midrst_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = CNT_W'(42);
    data_in = DATA_W'({$urandom(), $urandom()});
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_sclk", sclk, 1);
    check("midrst_shift", shift, 0);
    check("midrst_write_cfg", write_cfg, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_serial_out", serial_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_dout_valid", dout_valid, 0);
    model_dout = '0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_early", cmd_ready, 0);
    @(negedge clk);
    check("midrst_ready_release", cmd_ready, 1);
    check("midrst_busy_release", busy, 0);
    fill_lanes_random();
    run_cmd(2'b10, 30, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
